// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and oversampling constants shared by the UART blocks
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int OVERSAMPLE = 16;
    localparam int START_SAMPLE = 7;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with registered full/empty flags
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count, count_n;
    logic do_push, do_pop;
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign count_n = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count_n;
            full <= count_n == (AW+1)'(DEPTH);
            empty <= count_n == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: UART with baud generator, TX/RX FSMs and TX/RX FIFOs
module uart_ctrl import uart_pkg::*; #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_final_value,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic [DATA_BITS-1:0] tx_fifo_dataIn,
    input  logic                 tx_fifo_writeEn,
    output logic                 tx_fifo_Full,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 rx_fifo_readEn,
    output logic [DATA_BITS+1:0] rx_fifo_dataOut,
    output logic                 rx_fifo_Empty,
    output logic                 rx_overrun,
    input  logic                 clr_overrun
);
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic tick;
    state_t tx_state, tx_state_n, rx_state, rx_state_n;
    logic [4:0] tx_cnt;
    logic [3:0] rx_cnt;
    logic [2:0] tx_bit, rx_bit;
    logic [DATA_BITS-1:0] tx_shreg, tx_data, rx_shreg;
    logic tx_par, tx_par_en, tx_stop2, tx_empty, tx_pop, tx_done;
    logic [1:0] rx_sync;
    logic rx_s, rx_par_en, rx_par_odd, rx_perr, rx_done, rx_push, rx_full;
    logic [DATA_BITS+1:0] rx_word;

    assign tick = baud_cnt == baud_final_value;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) baud_cnt <= '0;
        else baud_cnt <= tick ? '0 : baud_cnt + DIV_WIDTH'(1);
    end

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_fifo_writeEn), .pop(tx_pop),
        .din(tx_fifo_dataIn), .dout(tx_data), .full(tx_fifo_Full), .empty(tx_empty)
    );

    // STOP stretches to two bit periods when two stop bits were latched
    assign tx_done = tick && tx_cnt == ((tx_state == STOP && tx_stop2) ? 5'(2*OVERSAMPLE-1) : 5'(OVERSAMPLE-1));
    assign tx_busy = tx_state != IDLE;
    assign tx = tx_state == START ? 1'b0 : tx_state == DATA ? tx_shreg[0] : tx_state == PARITY ? tx_par : 1'b1;
    always_comb begin
        tx_state_n = tx_state;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE: if (!tx_empty) begin
                tx_state_n = START;
                tx_pop = 1'b1;
            end
            START: if (tx_done) tx_state_n = DATA;
            DATA: if (tx_done && tx_bit == 3'(DATA_BITS-1)) tx_state_n = tx_par_en ? PARITY : STOP;
            PARITY: if (tx_done) tx_state_n = STOP;
            default: if (tx_done) tx_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_shreg <= '0;
            tx_par <= 1'b0;
            tx_par_en <= 1'b0;
            tx_stop2 <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_pop) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                tx_shreg <= tx_data;
                tx_par <= ^tx_data ^ parity_odd;
                tx_par_en <= parity_en;
                tx_stop2 <= stop2;
            end else if (tick) begin
                tx_cnt <= tx_done ? '0 : tx_cnt + 5'd1;
                if (tx_done && tx_state == DATA) begin
                    tx_shreg <= tx_shreg >> 1;
                    tx_bit <= tx_bit + 3'd1;
                end
            end
        end
    end

    assign rx_s = rx_sync[1];
    assign rx_done = tick && rx_cnt == (rx_state == START ? 4'(START_SAMPLE) : 4'(OVERSAMPLE-1));
    assign rx_push = rx_state == STOP && rx_done;
    assign rx_word = {~rx_s, rx_perr, rx_shreg};
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            IDLE: if (!rx_s) rx_state_n = START;
            START: if (rx_done) rx_state_n = rx_s ? IDLE : DATA;
            DATA: if (rx_done && rx_bit == 3'(DATA_BITS-1)) rx_state_n = rx_par_en ? PARITY : STOP;
            PARITY: if (rx_done) rx_state_n = STOP;
            default: if (rx_done) rx_state_n = IDLE;
        endcase
    end
    // configuration tracks the inputs while idle, so it freezes on the start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
            rx_state <= IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_shreg <= '0;
            rx_perr <= 1'b0;
            rx_par_en <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_state <= rx_state_n;
            if (rx_state == IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                rx_perr <= 1'b0;
                rx_par_en <= parity_en;
                rx_par_odd <= parity_odd;
            end else if (tick) begin
                rx_cnt <= rx_done ? '0 : rx_cnt + 4'd1;
                if (rx_done && rx_state == DATA) begin
                    rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                    rx_bit <= rx_bit + 3'd1;
                end
                if (rx_done && rx_state == PARITY) rx_perr <= rx_s != (^rx_shreg ^ rx_par_odd);
            end
            if (rx_push && rx_full && !rx_fifo_readEn) rx_overrun <= 1'b1;
            else if (clr_overrun) rx_overrun <= 1'b0;
        end
    end

    uart_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_fifo_readEn),
        .din(rx_word), .dout(rx_fifo_dataOut), .full(rx_full), .empty(rx_fifo_Empty)
    );
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: randomized scenario bench for uart_ctrl against a frame-level reference model
module tb_uart_ctrl;
    localparam int DB = 8;
    localparam int FD = 4;
    localparam int DW = 11;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [DW-1:0] baud_final_value = '0;
    logic parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
    logic [DB-1:0] tx_fifo_dataIn = '0;
    logic tx_fifo_writeEn = 1'b0, rx_fifo_readEn = 1'b0, clr_overrun = 1'b0;
    logic tx_fifo_Full, tx_busy, tx, rx, rx_fifo_Empty, rx_overrun;
    logic [DB+1:0] rx_fifo_dataOut;
    logic loop = 1'b0, rx_drv = 1'b1;
    int n_cmp = 0, n_bad = 0;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_ctrl #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .baud_final_value(baud_final_value),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .tx_fifo_dataIn(tx_fifo_dataIn), .tx_fifo_writeEn(tx_fifo_writeEn),
        .tx_fifo_Full(tx_fifo_Full), .tx_busy(tx_busy), .tx(tx), .rx(rx),
        .rx_fifo_readEn(rx_fifo_readEn), .rx_fifo_dataOut(rx_fifo_dataOut),
        .rx_fifo_Empty(rx_fifo_Empty), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun)
    );

    // Reference frame: start, data LSB first, optional parity, stop ones
    function automatic logic frame_bit(input logic [7:0] d, input logic pe, input logic po, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return d[k-1];
        if (k == DB + 1 && pe) return ^d ^ po;
        return 1'b1;
    endfunction

    task automatic push_tx(input logic [7:0] d);
        tx_fifo_dataIn = d;
        tx_fifo_writeEn = 1'b1;
        @(negedge clk);
        tx_fifo_writeEn = 1'b0;
    endtask

    task automatic check_tx_frame(input logic [7:0] d, input logic pe, input logic po, input logic s2, input int div, input bit scramble);
        int bp = 16 * (div + 1);
        int nb = DB + 2 + int'(pe) + int'(s2);
        int len = 0;
        int w = 0;
        while (!tx_busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (tx_busy && len < 16 * bp) begin
            if (len % bp == bp / 2) begin
                n_cmp++;
                if (tx !== frame_bit(d, pe, po, len / bp)) begin
                    n_bad++;
                    $display("FAIL tx_bit%0d byte=%h: got %b expected %b", len / bp, d, tx, frame_bit(d, pe, po, len / bp));
                end
            end
            if (scramble && len == 20) begin
                parity_en = 1'($urandom);
                parity_odd = 1'($urandom);
                stop2 = 1'($urandom);
            end
            len++;
            @(negedge clk);
        end
        n_cmp++;
        if (len < nb * bp - div || len > nb * bp) begin
            n_bad++;
            $display("FAIL tx_len byte=%h: got %0d cycles expected %0d..%0d", d, len, nb * bp - div, nb * bp);
        end
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic pe, input logic par_bit, input logic stop_bit);
        int nb = DB + 2 + int'(pe);
        for (int k = 0; k < nb; k++) begin
            rx_drv = k == 0 ? 1'b0 : k <= DB ? d[k-1] : (k == DB + 1 && pe) ? par_bit : stop_bit;
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic pop_check(input logic [9:0] exp, input string name);
        int w = 0;
        while (rx_fifo_Empty && w < 4000) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (rx_fifo_Empty || rx_fifo_dataOut !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (empty=%b) expected %h", name, rx_fifo_dataOut, rx_fifo_Empty, exp);
        end
        rx_fifo_readEn = 1'b1;
        @(negedge clk);
        rx_fifo_readEn = 1'b0;
    endtask

    task automatic expect_bit(input logic got, input logic exp, input string name);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        expect_bit(tx, 1'b1, "rst_tx");
        expect_bit(tx_busy, 1'b0, "rst_busy");
        expect_bit(tx_fifo_Full, 1'b0, "rst_full");
        expect_bit(rx_fifo_Empty, 1'b1, "rst_empty");
        expect_bit(rx_overrun, 1'b0, "rst_overrun");
        n_cmp++;
        if (rx_fifo_dataOut !== '0) begin
            n_bad++;
            $display("FAIL rst_dout: got %h expected 000", rx_fifo_dataOut);
        end
        reset = 1'b1;
        rx_fifo_readEn = 1'b1;
        @(negedge clk);
        rx_fifo_readEn = 1'b0;
        @(negedge clk);
        expect_bit(rx_fifo_Empty, 1'b1, "pop_empty_ignored");
        expect_bit(tx, 1'b1, "idle_tx");
    endtask

    task automatic test_loopback;
        loop = 1'b1;
        push_tx(8'hA5);
        push_tx(8'h3C);
        check_tx_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_tx_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        pop_check(10'h0A5, "loop_a5");
        pop_check(10'h03C, "loop_3c");
    endtask

    task automatic test_parity;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        push_tx(8'h07);
        check_tx_frame(8'h07, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        pop_check(10'h007, "par_loop");
        loop = 1'b0;
        drive_rx(8'h07, 1'b1, 1'b0, 1'b1);
        pop_check({2'b01, 8'h07}, "parity_err");
        parity_odd = 1'b1;
        drive_rx(8'h07, 1'b1, 1'b0, 1'b1);
        pop_check({2'b00, 8'h07}, "odd_parity_ok");
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_framing;
        drive_rx(8'h55, 1'b0, 1'b0, 1'b0);
        pop_check({2'b10, 8'h55}, "framing_err");
        repeat (40) @(negedge clk);
        expect_bit(rx_fifo_Empty, 1'b1, "no_push_after_low_stop");
    endtask

    task automatic test_glitch;
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        expect_bit(rx_fifo_Empty, 1'b1, "glitch_no_push");
        drive_rx(8'h5A, 1'b0, 1'b0, 1'b1);
        pop_check(10'h05A, "after_glitch");
    endtask

    task automatic test_overrun;
        logic [7:0] q[$];
        for (int i = 0; i < 5; i++) begin
            q.push_back(8'($urandom));
            drive_rx(q[i], 1'b0, 1'b0, 1'b1);
            if (i == 3) begin
                repeat (4) @(negedge clk);
                expect_bit(rx_overrun, 1'b0, "no_overrun_at_depth");
            end
        end
        repeat (4) @(negedge clk);
        expect_bit(rx_overrun, 1'b1, "overrun_set");
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        expect_bit(rx_overrun, 1'b0, "overrun_cleared");
        for (int i = 0; i < 4; i++) pop_check({2'b00, q[i]}, "overrun_keep");
        expect_bit(rx_fifo_Empty, 1'b1, "fifth_dropped");
    endtask

    task automatic test_back_to_back;
        logic [7:0] q[$];
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        fork
            begin
                for (int i = 0; i < 6; i++) push_tx(q[i]);
                expect_bit(tx_fifo_Full, 1'b1, "tx_full");
            end
            for (int i = 0; i < 5; i++) check_tx_frame(q[i], 1'b0, 1'b0, 1'b0, 0, 1'b0);
        join
        expect_bit(tx_fifo_Full, 1'b0, "tx_drained_full");
        repeat (200) @(negedge clk);
        expect_bit(tx_busy, 1'b0, "sixth_dropped");
    endtask

    task automatic test_random;
        int div = 0;
        loop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d = 8'($urandom);
            logic pe = 1'($urandom), po = 1'($urandom), s2 = 1'($urandom);
            if (div < 3) div += int'($urandom_range(0, 1));
            baud_final_value = DW'(div);
            parity_en = pe;
            parity_odd = po;
            stop2 = s2;
            push_tx(d);
            check_tx_frame(d, pe, po, s2, div, 1'b1);
            pop_check({2'b00, d}, "rand_loop");
        end
    endtask

    task automatic test_reset_midframe;
        int w = 0;
        reset = 1'b0;
        baud_final_value = '0;
        parity_en = 1'b0;
        stop2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_tx(8'hC3);
        while (!tx_busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (40) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        expect_bit(tx, 1'b1, "midrst_tx");
        expect_bit(tx_busy, 1'b0, "midrst_busy");
        expect_bit(rx_fifo_Empty, 1'b1, "midrst_empty");
        @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        expect_bit(rx_fifo_Empty, 1'b1, "midrst_no_push");
        expect_bit(tx_busy, 1'b0, "midrst_tx_fifo_empty");
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_parity;
        test_framing;
        test_glitch;
        test_overrun;
        test_back_to_back;
        test_random;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16: entries per FIFO; power of two, at least 2.
REQ-003 Parameter DIV_WIDTH, default 11: width of the baud divisor.
REQ-004 Port clk, input, 1: the only clock; one clock; reset is asynchronous and active-low.
REQ-005 Port reset, input, 1: asynchronous active-low reset.
REQ-006 Port baud_final_value, input, DIV_WIDTH: oversample tick divisor.
REQ-007 Port parity_en, input, 1: parity bit present.
REQ-008 Port parity_odd, input, 1: 1 selects odd parity, 0 selects even parity.
REQ-009 Port stop2, input, 1: 1 selects two stop bits, 0 selects one.
REQ-010 Port tx_fifo_dataIn, input, DATA_BITS: transmit write data.
REQ-011 Port tx_fifo_writeEn, input, 1: transmit FIFO push.
REQ-012 Port tx_fifo_Full, output, 1: transmit FIFO full.
REQ-013 Port tx_busy, output, 1: frame in progress on tx.
REQ-014 Port tx, output, 1: serial out, idle high.
REQ-015 Port rx, input, 1: serial in, asynchronous.
REQ-016 Port rx_fifo_readEn, input, 1: receive FIFO pop.
REQ-017 Port rx_fifo_dataOut, output, DATA_BITS+2: {framing_err, parity_err, data} at head; first-word-fall-through.
REQ-018 Port rx_fifo_Empty, output, 1: receive FIFO empty.
REQ-019 Port rx_overrun, output, 1: sticky overrun flag.
REQ-020 Port clr_overrun, input, 1: single-cycle pulse that clears rx_overrun.

Function
REQ-021 Baud counter: counts 0..baud_final_value; single-cycle tick when count equals baud_final_value, then returns to 0; a value of 0 ticks every cycle.
REQ-022 Bit period: 16 ticks; data bits sent and received LSB first.
REQ-023 Frame: start bit 0; DATA_BITS data bits; parity bit if enabled (XOR of data, inverted when parity_odd); stop bits of 1, count 1 or 2.
REQ-024 Configuration: parity_en, parity_odd and stop2 latched at frame start; mid-frame changes affect only the next frame.
REQ-025 TX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-026 TX, IDLE to START: on the first cycle with the TX FIFO not empty; pops the FIFO that same cycle and loads the shift register.
REQ-027 TX, PARITY: skipped when parity is disabled.
REQ-028 TX, STOP to IDLE: after 16 or 32 ticks; back-to-back frames carry no extra idle bit.
REQ-029 TX, tx_busy: high in every state except IDLE.
REQ-030 RX synchronisation: rx passes through a 2-flop synchroniser before use.
REQ-031 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-032 RX, IDLE to START: on synchronised rx equal to 0.
REQ-033 RX, START: input resampled at tick 7; a 1 is a false start and returns to IDLE with no push.
REQ-034 RX, DATA/PARITY/STOP sampling: each bit sampled 16 ticks after the previous sample point.
REQ-035 RX, parity_err: set when the received parity bit mismatches the computed parity.
REQ-036 RX, framing_err: set when the first stop bit samples 0; the second stop bit is not checked.
REQ-037 RX completion: at the first stop sample the word is pushed to the RX FIFO (including errored words) and the FSM returns to IDLE.
REQ-038 Overrun: completion while the RX FIFO is full drops the word and sets rx_overrun the next cycle.
REQ-039 Overrun clear: clr_overrun clears rx_overrun; a simultaneous set wins.
REQ-040 FIFO, push when full: ignored, except with a simultaneous pop, which accepts both and leaves count unchanged.
REQ-041 FIFO, pop when empty: ignored; simultaneous push and pop when empty performs the push only.
REQ-042 FIFO flags: Full and Empty are registered and reflect count after the edge; pointers wrap modulo FIFO_DEPTH.
REQ-043 FIFO latency: a pushed word appears at dataOut one cycle after the push.

Reset
REQ-044 Asserting reset: asynchronously forces both FSMs to IDLE, the baud counter and FIFO pointers to 0, tx to 1, tx_busy to 0, tx_fifo_Full to 0, rx_fifo_Empty to 1, rx_overrun to 0, and rx_fifo_dataOut to 0.
REQ-045 Mid-frame reset: a frame in progress is abandoned; no partial word is pushed.
REQ-046 Deassertion: normal operation begins on the first clk edge after reset deasserts.
REQ-047 Synchroniser reset: synchroniser flops reset to 1.

Structure
REQ-048 Shared package uart_pkg: FSM state enumeration, OVERSAMPLE=16, START_SAMPLE=7.
REQ-049 Sub-module uart_fifo (parameters WIDTH, DEPTH): instantiated twice; the baud generator, TX FSM and RX FSM are inline.

Verification
REQ-050 Loopback (tx to rx), DATA_BITS=8, divisor 0, no parity, 1 stop: push 0xA5, 0x3C -> rx pops 0xA5, 0x3C with both error bits 0; tx frame lasts 160 cycles.
REQ-051 Even parity, byte 0x07: tx parity bit 1; injected received parity 0 -> parity_err=1, data 0x07.
REQ-052 Stop bit forced low on a received 0x55 -> word {1,0,0x55} pushed.
REQ-053 Glitch: rx low for 5 ticks, then high -> no push, RX FSM back in IDLE.
REQ-054 FIFO_DEPTH=4: receive 5 frames without popping -> 4 words kept, 5th dropped, rx_overrun=1; clr_overrun pulse -> 0.
REQ-055 Reset asserted mid-data-bit of a tx frame -> tx=1 immediately, FIFOs empty, no rx push.
